// File: rtl/ib_tag_arbiter_pkg.sv
// Shared constants, helpers and types for the internal-bus tag arbiter.
package ib_tag_arbiter_pkg;

   localparam int DEF_PORTS         = 4;
   localparam int DEF_USR_TAG_WIDTH = 8;
   localparam int DEF_EP_TAG_WIDTH  = 5;

   // Ceiling log2 with a floor of one bit so a 2-port arbiter still has a port field.
   function automatic int log2(input int n);
      int w;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < n) begin
            w = i + 1;
         end
      end
      return w;
   endfunction

   localparam int DEF_PORT_W = log2(DEF_PORTS);

   // Table entry layout for the default configuration: owning port and original user tag.
   typedef struct packed {
      logic [DEF_PORT_W-1:0]        port;
      logic [DEF_USR_TAG_WIDTH-1:0] usr_tag;
   } tag_entry_t;

endpackage

// File: rtl/ib_tag_arbiter_if.sv
// Request/grant and completion signals between the user ports and the tag arbiter.
interface ib_tag_arbiter_if
   import ib_tag_arbiter_pkg::*;
#(
   parameter int PORTS         = DEF_PORTS,
   parameter int USR_TAG_WIDTH = DEF_USR_TAG_WIDTH,
   parameter int EP_TAG_WIDTH  = DEF_EP_TAG_WIDTH
);

   localparam int PORT_W = log2(PORTS);

   logic [PORTS-1:0]               req;
   logic [PORTS*USR_TAG_WIDTH-1:0] req_usr_tag;
   logic [PORTS-1:0]               gnt;
   logic [EP_TAG_WIDTH-1:0]        gnt_ep_tag;

   logic                           cpl_vld;
   logic [EP_TAG_WIDTH-1:0]        cpl_ep_tag;
   logic                           cpl_last;
   logic                           cpl_out_vld;
   logic [PORT_W-1:0]              cpl_port;
   logic [USR_TAG_WIDTH-1:0]       cpl_usr_tag;
   logic                           cpl_err;

   logic [EP_TAG_WIDTH:0]          free_cnt;

   modport master (
      output req, req_usr_tag, cpl_vld, cpl_ep_tag, cpl_last,
      input  gnt, gnt_ep_tag, cpl_out_vld, cpl_port, cpl_usr_tag, cpl_err, free_cnt
   );

   modport slave (
      input  req, req_usr_tag, cpl_vld, cpl_ep_tag, cpl_last,
      output gnt, gnt_ep_tag, cpl_out_vld, cpl_port, cpl_usr_tag, cpl_err, free_cnt
   );

endinterface

// File: rtl/ib_tag_pool.sv
// Free-tag bitmap with lowest-index allocation and a registered free counter.
module ib_tag_pool
   import ib_tag_arbiter_pkg::*;
#(
   parameter int EP_TAG_WIDTH = DEF_EP_TAG_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    alloc_en,
   input  logic                    release_en,
   input  logic [EP_TAG_WIDTH-1:0] release_tag,
   output logic [EP_TAG_WIDTH-1:0] alloc_tag,
   output logic                    avail,
   output logic                    release_tag_busy,
   output logic [EP_TAG_WIDTH:0]   free_cnt
);

   localparam int TAGS = 2 ** EP_TAG_WIDTH;
   localparam logic [EP_TAG_WIDTH:0] TAGS_CNT = (EP_TAG_WIDTH + 1)'(TAGS);

   logic [TAGS-1:0]       free_q, free_d;
   logic [EP_TAG_WIDTH:0] cnt_q, cnt_d;

   // Lowest free index wins; scanning downward lets the lowest hit overwrite the others.
   always_comb begin
      alloc_tag = '0;
      avail     = 1'b0;
      for (int i = TAGS - 1; i >= 0; i--) begin
         if (free_q[i]) begin
            alloc_tag = EP_TAG_WIDTH'(i);
            avail     = 1'b1;
         end
      end
   end

   assign release_tag_busy = ~free_q[release_tag];
   assign free_cnt         = cnt_q;

   // Apply allocate/release to the bitmap; the caller never releases the tag it is allocating.
   always_comb begin
      free_d = free_q;
      cnt_d  = cnt_q;
      if (alloc_en) begin
         free_d[alloc_tag] = 1'b0;
      end
      if (release_en) begin
         free_d[release_tag] = 1'b1;
      end
      case ({alloc_en, release_en})
         2'b10:   cnt_d = cnt_q - 1'b1;
         2'b01:   cnt_d = cnt_q + 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Pool state register; reset returns every tag to the pool.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         free_q <= '1;
         cnt_q  <= TAGS_CNT;
      end else begin
         free_q <= free_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/ib_tag_arbiter.sv
// Round-robin tag arbiter: hands out EP tags to user ports and translates completions back.
module ib_tag_arbiter
   import ib_tag_arbiter_pkg::*;
#(
   parameter int PORTS         = DEF_PORTS,
   parameter int USR_TAG_WIDTH = DEF_USR_TAG_WIDTH,
   parameter int EP_TAG_WIDTH  = DEF_EP_TAG_WIDTH
) (
   input  logic              clk,
   input  logic              rst_n,
   ib_tag_arbiter_if.slave   bus
);

   localparam int PORT_W = log2(PORTS);
   localparam int TAGS   = 2 ** EP_TAG_WIDTH;

   // Same layout as the package tag_entry_t, sized for this instance's parameters.
   typedef struct packed {
      logic [PORT_W-1:0]        port;
      logic [USR_TAG_WIDTH-1:0] usr_tag;
   } entry_t;

   logic [PORT_W-1:0]        rr_q, rr_d;
   logic [PORTS-1:0]         gnt;
   logic [PORT_W-1:0]        gnt_port;
   logic [USR_TAG_WIDTH-1:0] gnt_usr_tag;
   logic                     handshake;
   int                       best_dist;
   int                       cand_dist;

   logic [EP_TAG_WIDTH-1:0]  alloc_tag;
   logic                     avail;
   logic                     cpl_busy;
   logic                     release_en;
   logic [EP_TAG_WIDTH:0]    free_cnt;

   entry_t                   table_q [TAGS];
   entry_t                   wr_entry;
   entry_t                   cpl_entry;

   logic                     cpl_out_vld_q, cpl_out_vld_d;
   logic                     cpl_err_q, cpl_err_d;
   logic [PORT_W-1:0]        cpl_port_q, cpl_port_d;
   logic [USR_TAG_WIDTH-1:0] cpl_usr_tag_q, cpl_usr_tag_d;

   // Pick the requesting port closest to the RR pointer; nothing is granted while the pool is empty or in reset.
   always_comb begin
      gnt         = '0;
      gnt_port    = '0;
      gnt_usr_tag = '0;
      best_dist   = PORTS;
      cand_dist   = 0;
      if (avail && rst_n) begin
         for (int p = 0; p < PORTS; p++) begin
            cand_dist = (p + PORTS - int'(rr_q)) % PORTS;
            if (bus.req[p] && (cand_dist < best_dist)) begin
               best_dist   = cand_dist;
               gnt         = '0;
               gnt[p]      = 1'b1;
               gnt_port    = PORT_W'(p);
               gnt_usr_tag = bus.req_usr_tag[p*USR_TAG_WIDTH +: USR_TAG_WIDTH];
            end
         end
      end
   end

   assign handshake      = |gnt;
   assign wr_entry.port    = gnt_port;
   assign wr_entry.usr_tag = gnt_usr_tag;

   // Advance the RR pointer past the granted port, wrapping at the last port.
   always_comb begin
      rr_d = rr_q;
      if (handshake) begin
         if (int'(gnt_port) == PORTS - 1) begin
            rr_d = '0;
         end else begin
            rr_d = gnt_port + PORT_W'(1);
         end
      end
   end

   // RR pointer register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q <= '0;
      end else begin
         rr_q <= rr_d;
      end
   end

   // Ownership table; contents only matter once the matching pool bit says the tag is busy.
   always_ff @(posedge clk) begin
      if (handshake) begin
         table_q[alloc_tag] <= wr_entry;
      end
   end

   assign cpl_entry  = table_q[bus.cpl_ep_tag];
   assign release_en = bus.cpl_vld & bus.cpl_last & cpl_busy;

   // Translate a completion beat, or flag it when the tag is not currently allocated.
   always_comb begin
      cpl_out_vld_d = bus.cpl_vld & cpl_busy;
      cpl_err_d     = bus.cpl_vld & ~cpl_busy;
      cpl_port_d    = cpl_port_q;
      cpl_usr_tag_d = cpl_usr_tag_q;
      if (cpl_out_vld_d) begin
         cpl_port_d    = cpl_entry.port;
         cpl_usr_tag_d = cpl_entry.usr_tag;
      end
   end

   // Completion output registers, giving a fixed one-cycle translation latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cpl_out_vld_q <= 1'b0;
         cpl_err_q     <= 1'b0;
         cpl_port_q    <= '0;
         cpl_usr_tag_q <= '0;
      end else begin
         cpl_out_vld_q <= cpl_out_vld_d;
         cpl_err_q     <= cpl_err_d;
         cpl_port_q    <= cpl_port_d;
         cpl_usr_tag_q <= cpl_usr_tag_d;
      end
   end

   ib_tag_pool #(
      .EP_TAG_WIDTH (EP_TAG_WIDTH)
   ) u_pool (
      .clk              (clk),
      .rst_n            (rst_n),
      .alloc_en         (handshake),
      .release_en       (release_en),
      .release_tag      (bus.cpl_ep_tag),
      .alloc_tag        (alloc_tag),
      .avail            (avail),
      .release_tag_busy (cpl_busy),
      .free_cnt         (free_cnt)
   );

   assign bus.gnt         = gnt;
   assign bus.gnt_ep_tag  = alloc_tag;
   assign bus.cpl_out_vld = cpl_out_vld_q;
   assign bus.cpl_err     = cpl_err_q;
   assign bus.cpl_port    = cpl_port_q;
   assign bus.cpl_usr_tag = cpl_usr_tag_q;
   assign bus.free_cnt    = free_cnt;

endmodule

// File: tb/tb_ib_tag_arbiter.sv
// Directed bench for ib_tag_arbiter: grants checked inline, completions via a scoreboard monitor.
module tb_ib_tag_arbiter;
   import ib_tag_arbiter_pkg::*;

   localparam int PORTS = 4;
   localparam int UTW   = 8;
   localparam int ETW   = 5;

   typedef struct {
      logic       err;
      tag_entry_t ent;
   } exp_cpl_t;

   logic     clk = 1'b0;
   logic     rst_n = 1'b0;
   exp_cpl_t sb_q[$];
   exp_cpl_t mon_e;
   int       n_checks = 0;
   int       n_fail = 0;

   ib_tag_arbiter_if #(.PORTS(PORTS), .USR_TAG_WIDTH(UTW), .EP_TAG_WIDTH(ETW)) bus ();

   ib_tag_arbiter #(.PORTS(PORTS), .USR_TAG_WIDTH(UTW), .EP_TAG_WIDTH(ETW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_cpl(input logic err, input int port, input int usr);
      exp_cpl_t e;
      e.err         = err;
      e.ent.port    = DEF_PORT_W'(port);
      e.ent.usr_tag = DEF_USR_TAG_WIDTH'(usr);
      sb_q.push_back(e);
   endtask

   task automatic cpl_beat(input int tag, input logic last);
      bus.cpl_vld    = 1'b1;
      bus.cpl_ep_tag = ETW'(tag);
      bus.cpl_last   = last;
      step();
      bus.cpl_vld  = 1'b0;
      bus.cpl_last = 1'b0;
   endtask

   task automatic request(input int p, input int usr, input int exp_tag);
      bus.req[p] = 1'b1;
      bus.req_usr_tag[p*UTW +: UTW] = UTW'(usr);
      @(negedge clk);
      check_output($sformatf("gnt_port%0d", p), int'(bus.gnt), 1 << p);
      check_output($sformatf("gnt_ep_tag_port%0d", p), int'(bus.gnt_ep_tag), exp_tag);
      step();
      bus.req[p] = 1'b0;
   endtask

   task automatic check_free(input string name, input int exp);
      check_output(name, int'(bus.free_cnt), exp);
   endtask

   // Monitor: every translated or errored completion must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && (bus.cpl_out_vld || bus.cpl_err)) begin
         if (sb_q.size() == 0) begin
            check_output("cpl_unexpected", 1, 0);
         end else begin
            mon_e = sb_q.pop_front();
            check_output("cpl_out_vld", int'(bus.cpl_out_vld), int'(!mon_e.err));
            check_output("cpl_err", int'(bus.cpl_err), int'(mon_e.err));
            if (!mon_e.err) begin
               check_output("cpl_port", int'(bus.cpl_port), int'(mon_e.ent.port));
               check_output("cpl_usr_tag", int'(bus.cpl_usr_tag), int'(mon_e.ent.usr_tag));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      bus.req         = '1;
      bus.req_usr_tag = '0;
      bus.cpl_vld     = 1'b0;
      bus.cpl_ep_tag  = '0;
      bus.cpl_last    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_free("reset_free_cnt", 32);
      check_output("reset_gnt", int'(bus.gnt), 0);
      check_output("reset_cpl_out_vld", int'(bus.cpl_out_vld), 0);
      check_output("reset_cpl_err", int'(bus.cpl_err), 0);
      check_output("reset_cpl_port", int'(bus.cpl_port), 0);
      check_output("reset_cpl_usr_tag", int'(bus.cpl_usr_tag), 0);
      bus.req = '0;
      rst_n   = 1'b1;
      step();

      $display("[TB] single request and completion");
      request(0, 'h3C, 0);
      check_free("t1_free_after_grant", 31);
      expect_cpl(1'b0, 0, 'h3C);
      cpl_beat(0, 1'b1);
      check_free("t1_free_after_cpl", 32);
      step();

      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();

      $display("[TB] round-robin across all ports");
      for (int i = 0; i < PORTS; i++) begin
         bus.req_usr_tag[i*UTW +: UTW] = UTW'('h10 + i);
      end
      bus.req = '1;
      for (int c = 0; c < PORTS; c++) begin
         @(negedge clk);
         check_output($sformatf("rr_gnt_%0d", c), int'(bus.gnt), 1 << c);
         check_output($sformatf("rr_tag_%0d", c), int'(bus.gnt_ep_tag), c);
         step();
         bus.req[c] = 1'b0;
      end
      check_free("rr_free_cnt", 28);

      $display("[TB] fill the pool and recycle tag 7");
      for (int i = 4; i < 32; i++) begin
         request(0, i, i);
      end
      check_free("full_free_cnt", 0);
      bus.req[1] = 1'b1;
      bus.req_usr_tag[1*UTW +: UTW] = 8'hAB;
      @(negedge clk);
      check_output("full_gnt", int'(bus.gnt), 0);
      step();
      expect_cpl(1'b0, 0, 7);
      bus.cpl_vld    = 1'b1;
      bus.cpl_ep_tag = 5'd7;
      bus.cpl_last   = 1'b1;
      @(negedge clk);
      check_output("freed_not_grantable_same_cycle", int'(bus.gnt), 0);
      step();
      bus.cpl_vld  = 1'b0;
      bus.cpl_last = 1'b0;
      check_free("free_after_tag7", 1);
      @(negedge clk);
      check_output("regrant_gnt", int'(bus.gnt), 'b0010);
      check_output("regrant_tag", int'(bus.gnt_ep_tag), 7);
      step();
      bus.req[1] = 1'b0;
      check_free("free_after_regrant", 0);

      $display("[TB] grant and release in the same cycle");
      expect_cpl(1'b0, 2, 'h12);
      cpl_beat(2, 1'b1);
      check_free("free_after_tag2", 1);
      bus.req[3] = 1'b1;
      bus.req_usr_tag[3*UTW +: UTW] = 8'h5A;
      bus.cpl_vld    = 1'b1;
      bus.cpl_ep_tag = 5'd10;
      bus.cpl_last   = 1'b1;
      expect_cpl(1'b0, 0, 10);
      @(negedge clk);
      check_output("simul_gnt", int'(bus.gnt), 'b1000);
      check_output("simul_tag", int'(bus.gnt_ep_tag), 2);
      step();
      bus.req[3]   = 1'b0;
      bus.cpl_vld  = 1'b0;
      bus.cpl_last = 1'b0;
      check_free("simul_free_cnt", 1);
      request(1, 'h4D, 10);
      check_free("free_after_tag10", 0);
      expect_cpl(1'b0, 3, 'h5A);
      cpl_beat(2, 1'b0);
      check_free("free_after_nonlast", 0);

      $display("[TB] multi-beat completion on tag 5");
      expect_cpl(1'b0, 0, 5);
      cpl_beat(5, 1'b0);
      check_free("beat1_free_cnt", 0);
      expect_cpl(1'b0, 0, 5);
      cpl_beat(5, 1'b0);
      check_free("beat2_free_cnt", 0);
      expect_cpl(1'b0, 0, 5);
      cpl_beat(5, 1'b1);
      check_free("beat3_free_cnt", 1);

      $display("[TB] unallocated completion and reset mid-traffic");
      expect_cpl(1'b1, 0, 0);
      cpl_beat(5, 1'b1);
      check_free("err_free_cnt", 1);
      step();
      step();
      bus.req = '1;
      @(negedge clk);
      check_output("pre_reset_gnt", int'(bus.gnt), 'b0100);
      check_output("pre_reset_tag", int'(bus.gnt_ep_tag), 5);
      rst_n = 1'b0;
      #1;
      check_free("midreset_free_cnt", 32);
      check_output("midreset_gnt", int'(bus.gnt), 0);
      bus.req = '0;
      step();
      rst_n = 1'b1;
      step();

      $display("[TB] pointer wrap and stale tag");
      request(3, 'h33, 0);
      bus.req_usr_tag[0*UTW +: UTW] = 8'h44;
      bus.req_usr_tag[3*UTW +: UTW] = 8'h34;
      bus.req = 4'b1001;
      @(negedge clk);
      check_output("wrap_gnt", int'(bus.gnt), 'b0001);
      check_output("wrap_tag", int'(bus.gnt_ep_tag), 1);
      step();
      bus.req[0] = 1'b0;
      @(negedge clk);
      check_output("wrap_next_gnt", int'(bus.gnt), 'b1000);
      check_output("wrap_next_tag", int'(bus.gnt_ep_tag), 2);
      step();
      bus.req[3] = 1'b0;
      check_free("wrap_free_cnt", 29);
      expect_cpl(1'b1, 0, 0);
      cpl_beat(9, 1'b1);
      check_free("stale_free_cnt", 29);
      expect_cpl(1'b0, 3, 'h34);
      cpl_beat(2, 1'b1);
      check_free("final_free_a", 30);
      expect_cpl(1'b0, 0, 'h44);
      cpl_beat(1, 1'b1);
      check_free("final_free_b", 31);

      for (int w = 0; w < 20 && sb_q.size() != 0; w++) begin
         step();
      end
      check_output("scoreboard_drained", sb_q.size(), 0);
      repeat (3) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ib_tag_arbiter.md
Name: ib_tag_arbiter

Overview:
- Shares the internal-bus endpoint tag space between N user requesters that issue read requests.
- Each accepted request gets a free EP tag. The block records the owning port and user tag for that EP tag.
- On completion, the block translates the EP tag back to (port, user tag) and frees the tag on the last completion beat.
- Sits between the user-side request ports and the tag sequencer/endpoint, in front of the completion demux.

Parameters:
- PORTS, 4, number of requesters (2..8).
- USR_TAG_WIDTH, 8, user tag width.
- EP_TAG_WIDTH, 5, EP tag width; pool size TAGS = 2**EP_TAG_WIDTH.

Ports:
- CLK  in  1  clock.
- RESET  in  1  asynchronous, active-low reset.
- REQ  in  PORTS  per-port request valid.
- REQ_USR_TAG  in  PORTS*USR_TAG_WIDTH  per-port user tag; port i occupies slice i.
- GNT  out  PORTS  one-hot grant; a handshake is REQ[i]&GNT[i].
- GNT_EP_TAG  out  EP_TAG_WIDTH  EP tag assigned to the granted request.
- CPL_VLD  in  1  completion beat valid.
- CPL_EP_TAG  in  EP_TAG_WIDTH  EP tag of the completion beat.
- CPL_LAST  in  1  last beat for this tag.
- CPL_OUT_VLD  out  1  translated completion valid.
- CPL_PORT  out  log2(PORTS)  owning port.
- CPL_USR_TAG  out  USR_TAG_WIDTH  original user tag.
- CPL_ERR  out  1  pulse: completion for a tag that is not allocated.
- FREE_CNT  out  EP_TAG_WIDTH+1  number of free tags.

Behaviour:
- Reset (RESET=0, async):
  - all tags free; FREE_CNT=TAGS; RR pointer=0.
  - GNT=0, CPL_OUT_VLD=0, CPL_ERR=0, CPL_PORT=0, CPL_USR_TAG=0.
  - table contents are don't-care.
- Grant path (combinational within the cycle, table update on the clock edge):
  - When any free tag exists, GNT selects one requesting port round-robin, starting from the RR pointer.
  - GNT_EP_TAG = lowest-index free tag.
  - On handshake: mark the tag used, write {port, usr_tag} into table[tag], set RR pointer to granted port+1 (mod PORTS).
  - No free tag -> GNT=0. Requesters hold REQ and the tag stable until granted.
- Completion path, fixed latency 1:
  - A CPL_VLD beat at cycle t produces CPL_OUT_VLD, CPL_PORT and CPL_USR_TAG at t+1, read from table[CPL_EP_TAG].
  - CPL_VLD & CPL_LAST frees the tag at the edge ending cycle t.
  - Non-last beats do not change the pool.
- Unallocated tag: CPL_VLD on an unallocated tag -> CPL_ERR=1 at t+1, CPL_OUT_VLD=0, no pool change.
- Simultaneous events:
  - A tag freed in cycle t is not grantable until t+1 (allocation uses the pre-edge bitmap).
  - Grant and free in the same cycle: FREE_CNT unchanged.
  - Grant only: FREE_CNT-1. Free only: FREE_CNT+1.
- FREE_CNT is registered and always equals the popcount of the free bitmap.
- Wrap-around: the RR pointer wraps from PORTS-1 to 0. Tag choice is always lowest free index, never rotated.
- Reset mid-operation drops all outstanding tags. Later completions for those tags report CPL_ERR.
- Only one grant per cycle.

Decomposition:
- Package ib_tag_arbiter_pkg holds:
  - typedef for the table entry {port, usr_tag};
  - a log2 function;
  - default parameter constants.
- Sub-module ib_tag_pool owns:
  - free bitmap, lowest-free priority encoder and FREE_CNT;
  - interface: alloc/free strobes plus tag in/out.
- The round-robin arbiter and the table stay in the top level.

Test Plan:
- Reset, then REQ=0001 with usr tag 0x3C -> GNT=0001, GNT_EP_TAG=0, FREE_CNT=31 next cycle. CPL_VLD+CPL_LAST on tag 0 -> next cycle CPL_PORT=0, CPL_USR_TAG=0x3C; FREE_CNT back to 32.
- REQ=1111 held for 4 cycles -> grants to ports 0,1,2,3 in order with EP tags 0,1,2,3.
- Fill all 32 tags -> FREE_CNT=0, GNT=0 while REQ is held. Free tag 7 at cycle t -> grant with tag 7 at t+1, not at t.
- Grant and CPL_LAST of a different tag in the same cycle -> FREE_CNT unchanged; both bitmap bits correct.
- 3-beat completion on tag 5 with CPL_LAST only on beat 3 -> three CPL_OUT_VLD pulses; tag 5 stays busy until after beat 3.
- Completion on never-granted tag 9 -> CPL_ERR pulse, CPL_OUT_VLD=0. Assert RESET mid-traffic -> FREE_CNT=32 immediately, GNT=0.
